// File: rtl/aes_dec_pkg.sv
// aes_dec_pkg: shared types and constants for the AES decrypt arbiter
package aes_dec_pkg;
  localparam int BLK_W = 128;
  localparam int TIMEOUT_DEF = 64;
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;
endpackage

// File: rtl/aes_rr_arb2.sv
// aes_rr_arb2: 2-way round-robin grant with a favoured-index pointer
module aes_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  input  logic       en,
  output logic [1:0] grant
);
  logic ptr;
  assign grant = (valid == 2'b11) ? (ptr ? 2'b10 : 2'b01) : valid;
  // favour the loser next time
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr <= 1'b0;
    else if (en && |valid) ptr <= ~grant[1];
endmodule

// File: rtl/aes_dec_arbiter.sv
// aes_dec_arbiter: shares one AES decrypt core between two requesters
// with round-robin grant and a watchdog that aborts stalled jobs.
module aes_dec_arbiter
  import aes_dec_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF,
  parameter int CNT_W          = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic             req1_valid,
  output logic             req0_ready,
  output logic             req1_ready,
  input  logic [BLK_W-1:0] req0_ct,
  input  logic [BLK_W-1:0] req1_ct,
  input  logic [BLK_W-1:0] req0_key,
  input  logic [BLK_W-1:0] req1_key,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [BLK_W-1:0] rsp_data,
  output logic             rsp_err,
  output logic             core_decrypt,
  output logic [BLK_W-1:0] core_ct,
  output logic [BLK_W-1:0] core_key,
  input  logic             core_done,
  input  logic [BLK_W-1:0] core_dout,
  output logic             busy
);
  state_t           state, state_n;
  logic             run, arb_en, timeout, granted;
  logic [CNT_W-1:0] wd;
  logic [1:0]       grant;
  // run holds off grants until the first edge after reset release
  assign arb_en       = run && state == IDLE;
  assign req0_ready   = arb_en & grant[0];
  assign req1_ready   = arb_en & grant[1];
  assign granted      = req0_ready | req1_ready;
  assign timeout      = wd == CNT_W'(TIMEOUT_CYCLES - 1);
  assign core_decrypt = state == LAUNCH;
  assign rsp_valid    = state == RESP;
  assign busy         = state != IDLE;
  aes_rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .valid ({req1_valid, req0_valid}),
    .en    (arb_en),
    .grant (grant)
  );
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = granted ? LAUNCH : IDLE;
      LAUNCH:  state_n = WAIT;
      WAIT:    state_n = (core_done || timeout) ? RESP : WAIT;
      RESP:    state_n = rsp_ready ? IDLE : RESP;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      run   <= 1'b0;
    end else begin
      state <= state_n;
      run   <= 1'b1;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      core_ct  <= '0;
      core_key <= '0;
      rsp_id   <= 1'b0;
      wd       <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      if (granted) begin
        core_ct  <= req1_ready ? req1_ct : req0_ct;
        core_key <= req1_ready ? req1_key : req0_key;
        rsp_id   <= req1_ready;
      end
      if (state == LAUNCH) wd <= '0;
      else if (state == WAIT && !core_done) wd <= wd + 1'b1;
      // done in the final watchdog cycle still counts as success
      if (state == WAIT && (core_done || timeout)) begin
        rsp_data <= core_done ? core_dout : '0;
        rsp_err  <= !core_done;
      end
    end
endmodule

// File: tb/tb_aes_dec_arbiter.sv
// tb_aes_dec_arbiter: randomized self-checking bench with a latency-programmable
// core stub and a job-level reference model (round-robin, latency, result).
module tb_aes_dec_arbiter;
  localparam int T = 64;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  logic clk = 0, rst_n = 0;
  logic req0_valid = 0, req1_valid = 0, req0_ready, req1_ready;
  logic [127:0] req0_ct = 0, req1_ct = 0, req0_key = 0, req1_key = 0;
  logic rsp_valid, rsp_ready = 0, rsp_id, rsp_err;
  logic [127:0] rsp_data, core_ct, core_key, core_dout;
  logic core_decrypt, core_done, busy;
  int total = 0, bad = 0;
  int lat = 0;
  bit spur = 0;
  bit mptr = 0;
  bit stub_on;
  int cnt;
  logic [127:0] s_ct, s_key;

  aes_dec_arbiter #(.TIMEOUT_CYCLES(T), .CNT_W(7)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_ct(req0_ct), .req1_ct(req1_ct), .req0_key(req0_key), .req1_key(req1_key),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .core_decrypt(core_decrypt), .core_ct(core_ct), .core_key(core_key),
    .core_done(core_done), .core_dout(core_dout), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] ref_dec(input logic [127:0] c, input logic [127:0] k);
    return (c == FIPS_CT && k == FIPS_KEY) ? FIPS_PT : c ^ {k[63:0], k[127:64]};
  endfunction

  // core stub: done arrives in WAIT cycle index lat (lat < 0 never)
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stub_on <= 0; cnt <= 0; s_ct <= 0; s_key <= 0;
    end else if (core_decrypt) begin
      stub_on <= 1; cnt <= 0; s_ct <= core_ct; s_key <= core_key;
    end else if (stub_on) begin
      if (core_done) stub_on <= 0;
      else cnt <= cnt + 1;
    end
  assign core_done = spur || (stub_on && cnt == lat);
  assign core_dout = ref_dec(s_ct, s_key);

  function automatic int pick(input bit v0, input bit v1);
    int w;
    w = (v0 && v1) ? int'(mptr) : (v1 ? 1 : 0);
    mptr = (w == 0);
    return w;
  endfunction

  function automatic bit ok_lat(input int l);
    return l >= 0 && l < T;
  endfunction

  function automatic int exp_k(input int l);
    return 3 + (ok_lat(l) ? l : T - 1);
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic do_job(input bit v0, input bit v1, input logic [127:0] c0, input logic [127:0] k0,
                        input logic [127:0] c1, input logic [127:0] k1, input bit keep,
                        output int gid, output int k, output logic [127:0] d, output logic id,
                        output logic e);
    req0_ct = c0; req0_key = k0; req1_ct = c1; req1_key = k1;
    req0_valid = v0; req1_valid = v1;
    gid = -1; k = -1; d = 'x; id = 'x; e = 'x;
    #1;
    for (int i = 0; i < 50 && gid < 0; i++) begin
      if (req0_ready) gid = 0;
      else if (req1_ready) gid = 1;
      else begin @(negedge clk); #1; end
    end
    if (gid < 0) begin
      total++; bad++;
      $display("FAIL grant_wait: no ready within 50 cycles");
      return;
    end
    @(negedge clk);
    if (!keep) begin req0_valid = 0; req1_valid = 0; end
    k = 1; #1;
    while (!rsp_valid && k < 300) begin @(negedge clk); k++; #1; end
    d = rsp_data; id = rsp_id; e = rsp_err;
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; req0_valid = 1; req1_valid = 1;
    #1;
    total++;
    if ({req0_ready, req1_ready, rsp_valid, busy, core_decrypt, rsp_err, rsp_id} !== 7'b0) begin
      bad++; $display("FAIL reset_ctrl: got %b want 0", {req0_ready, req1_ready, rsp_valid, busy, core_decrypt, rsp_err, rsp_id});
    end
    repeat (2) @(negedge clk);
    #1;
    total++;
    if ((rsp_data | core_ct | core_key) !== 128'b0) begin
      bad++; $display("FAIL reset_data: got %h want 0", rsp_data | core_ct | core_key);
    end
    rst_n = 1; #1;
    total++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      bad++; $display("FAIL grant_before_edge: got %b want 00", {req0_ready, req1_ready});
    end
    req0_valid = 0; req1_valid = 0;
    mptr = 0;
    @(negedge clk);
  endtask

  task automatic test_fips();
    int gid, k, w; logic [127:0] d; logic id, e;
    lat = 3; w = pick(1, 0);
    do_job(1, 0, FIPS_CT, FIPS_KEY, 0, 0, 0, gid, k, d, id, e);
    total++;
    if (gid !== w || id !== 1'(w) || d !== FIPS_PT || e !== 0) begin
      bad++; $display("FAIL fips: got gid=%0d id=%b d=%h e=%b want gid=%0d d=%h e=0", gid, id, d, e, w, FIPS_PT);
    end
    total++;
    if (k != exp_k(lat)) begin bad++; $display("FAIL fips_latency: got %0d want %0d", k, exp_k(lat)); end
  endtask

  task automatic test_alternate();
    int gid, k, w; logic [127:0] d, c0, k0, c1, k1; logic id, e;
    for (int j = 0; j < 4; j++) begin
      lat = $urandom_range(0, 5);
      c0 = rnd128(); k0 = rnd128(); c1 = rnd128(); k1 = rnd128();
      w = pick(1, 1);
      do_job(1, 1, c0, k0, c1, k1, 1, gid, k, d, id, e);
      total++;
      if (gid !== w || id !== 1'(w) || d !== (w ? ref_dec(c1, k1) : ref_dec(c0, k0)) || e !== 0 || k != exp_k(lat)) begin
        bad++; $display("FAIL alternate[%0d]: got gid=%0d id=%b e=%b k=%0d want gid=%0d k=%0d", j, gid, id, e, k, w, exp_k(lat));
      end
    end
    req0_valid = 0; req1_valid = 0;
  endtask

  task automatic test_random();
    int gid, k, w, v; logic [127:0] d, c0, k0, c1, k1; logic id, e;
    for (int j = 0; j < 8; j++) begin
      spur = 1; @(negedge clk); spur = 0;
      v = $urandom_range(1, 3);
      lat = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, 8));
      c0 = rnd128(); k0 = rnd128(); c1 = rnd128(); k1 = rnd128();
      w = pick(v[0], v[1]);
      do_job(v[0], v[1], c0, k0, c1, k1, 0, gid, k, d, id, e);
      total++;
      if (gid !== w || id !== 1'(w)) begin
        bad++; $display("FAIL rand_grant[%0d]: got gid=%0d id=%b want %0d", j, gid, id, w);
      end
      total++;
      if (k != exp_k(lat) || e !== !ok_lat(lat) ||
          d !== (ok_lat(lat) ? (w ? ref_dec(c1, k1) : ref_dec(c0, k0)) : 128'b0)) begin
        bad++; $display("FAIL rand_rsp[%0d]: got k=%0d e=%b d=%h want k=%0d e=%b", j, k, e, d, exp_k(lat), !ok_lat(lat));
      end
    end
  endtask

  task automatic test_timeout_edges();
    int gid, k, w; logic [127:0] d, c, kk; logic id, e;
    int lats[3] = '{-1, T - 1, T};
    foreach (lats[j]) begin
      lat = lats[j];
      c = rnd128(); kk = rnd128();
      w = pick(0, 1);
      do_job(0, 1, 0, 0, c, kk, 0, gid, k, d, id, e);
      total++;
      if (k != T + 2) begin bad++; $display("FAIL timeout_latency[%0d]: got %0d want %0d", lat, k, T + 2); end
      total++;
      if (id !== 1'(w) || e !== !ok_lat(lat) || d !== (ok_lat(lat) ? ref_dec(c, kk) : 128'b0)) begin
        bad++; $display("FAIL timeout_rsp[%0d]: got id=%b e=%b d=%h want e=%b", lat, id, e, d, !ok_lat(lat));
      end
    end
  endtask

  task automatic test_stall();
    int n, gid, k, w; logic [127:0] c, kk, c1, k1, d, exp_d; logic id, e;
    lat = 2; c = rnd128(); kk = rnd128(); c1 = rnd128(); k1 = rnd128();
    w = pick(1, 0); exp_d = ref_dec(c, kk);
    req0_ct = c; req0_key = kk; req0_valid = 1; #1;
    n = 0;
    while (!req0_ready && n < 20) begin @(negedge clk); #1; n++; end
    @(negedge clk); req0_valid = 0; #1;
    n = 0;
    while (!rsp_valid && n < 50) begin @(negedge clk); #1; n++; end
    req1_ct = c1; req1_key = k1; req1_valid = 1; #1;
    for (int i = 0; i < 10; i++) begin
      total++;
      if (rsp_valid !== 1 || rsp_data !== exp_d || rsp_id !== 1'(w) || rsp_err !== 0 || req1_ready !== 0) begin
        bad++; $display("FAIL stall[%0d]: got v=%b d=%h id=%b e=%b r1=%b want v=1 d=%h", i, rsp_valid, rsp_data, rsp_id, rsp_err, req1_ready, exp_d);
      end
      @(negedge clk); #1;
    end
    rsp_ready = 1; #1;
    total++;
    if (req1_ready !== 0) begin bad++; $display("FAIL stall_accept_ready: got %b want 0", req1_ready); end
    @(negedge clk); rsp_ready = 0; #1;
    w = pick(0, 1);
    total++;
    if (req1_ready !== 1) begin bad++; $display("FAIL stall_next_grant: got %b want 1", req1_ready); end
    do_job(0, 1, 0, 0, c1, k1, 0, gid, k, d, id, e);
    total++;
    if (gid !== w || id !== 1 || d !== ref_dec(c1, k1) || e !== 0) begin
      bad++; $display("FAIL stall_followup: got gid=%0d id=%b d=%h e=%b want gid=1 d=%h", gid, id, d, e, ref_dec(c1, k1));
    end
  endtask

  task automatic test_reset_mid();
    int n, gid, k, w; logic [127:0] d, c, kk; logic id, e;
    bit seen;
    lat = -1;
    req0_ct = rnd128(); req0_key = rnd128(); req0_valid = 1; #1;
    n = 0;
    while (!req0_ready && n < 20) begin @(negedge clk); #1; n++; end
    @(negedge clk); req0_valid = 0;
    repeat (4) @(negedge clk);
    #2 rst_n = 0; #1;
    total++;
    if ({busy, rsp_valid, core_decrypt, req0_ready, req1_ready, rsp_err} !== 6'b0 || (core_ct | core_key | rsp_data) !== 128'b0) begin
      bad++; $display("FAIL reset_mid: got ctrl=%b data=%h want 0", {busy, rsp_valid, core_decrypt, req0_ready, req1_ready, rsp_err}, core_ct | core_key | rsp_data);
    end
    @(negedge clk); rst_n = 1; mptr = 0;
    seen = 0;
    repeat (5) begin @(negedge clk); #1; seen |= rsp_valid | busy; end
    total++;
    if (seen !== 0) begin bad++; $display("FAIL reset_no_rsp: got %b want 0", seen); end
    lat = 1; c = rnd128(); kk = rnd128();
    w = pick(1, 1);
    do_job(1, 1, c, kk, rnd128(), rnd128(), 0, gid, k, d, id, e);
    total++;
    if (gid !== w || d !== ref_dec(c, kk) || e !== 0 || k != exp_k(lat)) begin
      bad++; $display("FAIL reset_recover: got gid=%0d e=%b k=%0d want gid=%0d k=%0d", gid, e, k, w, exp_k(lat));
    end
  endtask

  initial begin
    test_reset();
    test_fips();
    test_alternate();
    test_random();
    test_timeout_edges();
    test_stall();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
